// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and scheduler FSM encoding shared by alu and alu_sched.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational datapath; unknown opcodes execute as add, carry is always that of a+b.
module alu import alu_pkg::*; #(
    parameter int DW = 64
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    op_i,
    output logic [DW-1:0] y_o,
    output logic          carry_o
);
    logic [DW:0] sum;
    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = sum[DW];
    assign y_o = op_i == OP_SUB   ? a_i - b_i :
                 op_i == OP_MUL   ? a_i * b_i :
                 op_i == OP_DIV   ? a_i / b_i :
                 op_i == OP_PASSB ? b_i :
                 op_i == OP_AND   ? a_i & b_i :
                 op_i == OP_OR    ? a_i | b_i :
                 op_i == OP_XOR   ? a_i ^ b_i :
                 sum[DW-1:0];
endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin front end for a shared alu, IDLE -> EXEC -> RESP.
// Define ALU_SCHED_DIVZERO_EN to return all-ones data with resp_err on divide by zero.
module alu_sched import alu_pkg::*; #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [3:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req1_op,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_carry,
    output logic          resp_id,
    output logic          resp_err,
    output logic          busy
);
    state_t        state_q;
    logic          last_q, id_q, alu_c, divz, gnt0, gnt1;
    logic [DW-1:0] a_q, b_q, alu_y;
    logic [3:0]    op_q;

    // last_q holds the requester served most recently; the other one wins a tie
    assign gnt1 = req1_valid && (!req0_valid || !last_q);
    assign gnt0 = req0_valid && !gnt1;
    assign req0_ready = !rst && state_q == S_IDLE && gnt0;
    assign req1_ready = !rst && state_q == S_IDLE && gnt1;
    assign resp_valid = state_q == S_RESP;
    assign busy       = state_q != S_IDLE;

`ifdef ALU_SCHED_DIVZERO_EN
    assign divz = op_q == OP_DIV && b_q == '0;
`else
    assign divz = 1'b0;
`endif

    alu #(.DW(DW)) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .y_o     (alu_y),
        .carry_o (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (gnt0 || gnt1) begin
                a_q     <= gnt1 ? req1_a : req0_a;
                b_q     <= gnt1 ? req1_b : req0_b;
                op_q    <= gnt1 ? req1_op : req0_op;
                id_q    <= gnt1;
                state_q <= S_EXEC;
            end
        end else if (state_q == S_EXEC) begin
            resp_data  <= divz ? '1 : alu_y;
            resp_carry <= alu_c;
            resp_id    <= id_q;
            resp_err   <= divz;
            state_q    <= S_RESP;
        end else if (resp_ready) begin
            last_q  <= resp_id;
            state_q <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized scoreboard bench for alu_sched against a spec-level model.
// Honours ALU_SCHED_DIVZERO_EN when predicting divide-by-zero results.
module tb_alu_sched;
    localparam int DW = 64;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          carry;
        logic          id;
        logic          err;
        logic          chk;
    } exp_t;

    logic          clk = 0, rst = 1;
    logic          req0_valid = 0, req1_valid = 0, resp_ready = 0;
    logic          req0_ready, req1_ready, resp_valid, resp_carry, resp_id, resp_err, busy;
    logic [DW-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, resp_data;
    logic [3:0]    req0_op = 0, req1_op = 0;

    req_t rq0[$], rq1[$];
    exp_t sb[$];
    int   nvec = 0, nerr = 0, cyc = 0, acc_c = 0, hold = 0;
    bit   outstanding = 0, last = 1, rnd_rr = 0;

    alu_sched #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input req_t r, input logic id);
        exp_t e;
        logic [DW:0] s = {1'b0, r.a} + {1'b0, r.b};
        e.carry = s[DW];
        e.id    = id;
        e.err   = 1'b0;
        e.chk   = 1'b1;
        case (r.op)
            4'b0001: e.data = r.a - r.b;
            4'b0010: e.data = r.a * r.b;
            4'b0011:
                if (r.b == 0) begin
`ifdef ALU_SCHED_DIVZERO_EN
                    e.data = '1;
                    e.err  = 1'b1;
`else
                    e.data = '0;
                    e.chk  = 1'b0;
`endif
                end else e.data = r.a / r.b;
            4'b0111: e.data = r.b;
            4'b1000: e.data = r.a & r.b;
            4'b1001: e.data = r.a | r.b;
            4'b1010: e.data = r.a ^ r.b;
            default: e.data = r.a + r.b;
        endcase
        return e;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : {$urandom(), $urandom()};
    endfunction

    task automatic push(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op);
        req_t r;
        r.a = a;
        r.b = b;
        r.op = op;
        if (who == 0) rq0.push_back(r);
        else rq1.push_back(r);
    endtask

    task automatic tick(input bit do_rst);
        bit w, e0, e1, a0, a1;
        req_t r;
        @(negedge clk);
        rst = do_rst;
        if (resp_valid && hold > 0) begin
            resp_ready = 0;
            hold--;
        end else resp_ready = rnd_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
        req0_valid = rq0.size() > 0;
        req1_valid = rq1.size() > 0;
        if (req0_valid) {req0_a, req0_b, req0_op} = {rq0[0].a, rq0[0].b, rq0[0].op};
        else {req0_a, req0_b, req0_op} = {rnd(), rnd(), 4'($urandom())};
        if (req1_valid) {req1_a, req1_b, req1_op} = {rq1[0].a, rq1[0].b, rq1[0].op};
        else {req1_a, req1_b, req1_op} = {rnd(), rnd(), 4'($urandom())};
        #1;
        w  = (req0_valid && req1_valid) ? !last : req1_valid;
        e0 = !rst && !outstanding && req0_valid && !w;
        e1 = !rst && !outstanding && req1_valid && w;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("busy", busy, outstanding);
        if (!outstanding) chk("resp_valid_idle", resp_valid, 0);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (a0 || a1) acc_c = cyc;
        @(posedge clk);
        if (do_rst) begin
            sb.delete();
            outstanding = 0;
            last = 1;
        end else if (a0 || a1) begin
            r = a1 ? rq1.pop_front() : rq0.pop_front();
            sb.push_back(model(r, a1));
            outstanding = 1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || outstanding) && n < budget) begin
            tick(0);
            n++;
        end
        chk("drain_timeout", DW'(n < budget), 1);
    endtask

    initial begin
        bit seen = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst || !resp_valid) seen = 0;
            else if (sb.size() == 0) chk("spurious_resp", resp_valid, 0);
            else begin
                if (!seen) chk("latency", DW'(cyc - acc_c), 2);
                seen = 1;
                if (sb[0].chk) chk("resp_data", resp_data, sb[0].data);
                chk("resp_carry", resp_carry, sb[0].carry);
                chk("resp_id", resp_id, sb[0].id);
                chk("resp_err", resp_err, sb[0].err);
                if (resp_ready) begin
                    @(posedge clk);
                    last = sb[0].id;
                    sb.delete(0);
                    outstanding = 0;
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        req0_valid = 1;
        req1_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_carry", resp_carry, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);
        req0_valid = 0;
        req1_valid = 0;
        push(0, 10, 4, 4'b0001);
        push(1, 'hF0, 'h3C, 4'b1000);
        drain(40);
        push(0, 1, 2, 4'b0000);
        push(1, 3, 4, 4'b0010);
        drain(40);
        push(0, 5, 3, 4'b0000);
        drain(20);
        push(1, {DW{1'b1}}, 1, 4'b0000);
        drain(20);
        hold = 5;
        push(0, 'h1234, 'h0F0F, 4'b1010);
        drain(30);
        push(0, 7, 0, 4'b0011);
        push(1, 2, 2, 4'b1111);
        push(0, 100, 7, 4'b0011);
        push(1, 9, 'hABC, 4'b0111);
        drain(60);
        push(0, 9, 9, 4'b0010);
        n = 0;
        while (!outstanding && n < 10) begin
            tick(0);
            n++;
        end
        chk("accept_timeout", DW'(outstanding), 1);
        push(0, 20, 22, 4'b1001);
        push(1, 30, 31, 4'b0000);
        tick(1);
        drain(60);
        rnd_rr = 1;
        repeat (400) begin
            if (rq0.size() < 2 && $urandom_range(0, 2) == 0) push(0, rnd(), rnd(), 4'($urandom()));
            if (rq1.size() < 2 && $urandom_range(0, 2) == 0) push(1, rnd(), rnd(), 4'($urandom()));
            tick(0);
        end
        drain(400);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
